vga_sync_decoder: RTL and testbench

// - Sink side of the 640x480 VGA timing interface: samples h_sync/v_sync/RGB as produced by the display timing generator.
// - Recovers the pixel coordinate and pixel value, and checks line/frame timing.
// - Declares lock only after repeated good frames; feeds the simulator's frame capture and on-chip self-check.

---
 rtl/vga_sync_decoder.sv | 180 ++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Sink-side 640x480 VGA timing recovery: pixel coordinate/value decode, line/frame checks, lock FSM.
// Optional previous-frame pixel checksum on frame_sum: define VGA_DEC_CHECKSUM_EN.
module vga_sync_decoder #(
  parameter int HPW         = 96,
  parameter int HB          = 48,
  parameter int HD          = 640,
  parameter int HF          = 16,
  parameter int VPW         = 2,
  parameter int VB          = 29,
  parameter int VD          = 480,
  parameter int VF          = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic [15:0] frame_sum
);

  localparam logic [10:0] L_HTOTAL = 11'(HPW + HB + HD + HF);
  localparam logic [10:0] L_HA0    = 11'(HPW + HB);
  localparam logic [10:0] L_HA1    = 11'(HPW + HB + HD - 1);
  localparam logic [9:0]  L_VTOTAL = 10'(VPW + VB + VD + VF);
  localparam logic [9:0]  L_VA0    = 10'(VPW + VB);
  localparam logic [9:0]  L_VA1    = 10'(VPW + VB + VD - 1);
  localparam logic [3:0]  L_LOCK   = 4'(LOCK_FRAMES);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic        r_h_d;
  logic        r_v_d;
  logic [10:0] r_hcnt;
  logic [9:0]  r_vcnt;
  logic        r_pend;
  logic [1:0]  r_state;
  logic [3:0]  r_good;

  logic        w_h_fall;
  logic        w_v_fall;
  logic        w_fs;
  logic [10:0] w_line_len;
  logic [9:0]  w_frame_lines;
  logic [10:0] w_hcnt;
  logic [9:0]  w_vcnt;
  logic        w_err_sat;
  logic        w_err_line;
  logic        w_err_frame;
  logic        w_err;
  logic [1:0]  w_state_nxt;
  logic [3:0]  w_good_nxt;
  logic        w_active;

  // w_hcnt/w_vcnt are the position of the pixel being sampled this cycle.
  always_comb begin
    w_h_fall      = r_h_d & ~h_sync;
    w_v_fall      = r_v_d & ~v_sync;
    w_fs          = w_h_fall & (w_v_fall | r_pend);
    w_line_len    = r_hcnt + 11'd1;
    w_frame_lines = r_vcnt + 10'd1;

    w_hcnt = w_line_len;
    if (w_h_fall)
      w_hcnt = '0;
    else if (r_hcnt == '1)
      w_hcnt = r_hcnt;

    w_vcnt = r_vcnt;
    if (w_fs)
      w_vcnt = '0;
    else if (w_h_fall && (r_vcnt != '1))
      w_vcnt = w_frame_lines;

    w_err_sat   = ~w_h_fall & (r_hcnt == 11'd2046);
    w_err_line  = w_h_fall & (w_line_len != L_HTOTAL) & (r_state != S_SEARCH);
    w_err_frame = w_fs & (w_frame_lines != L_VTOTAL) & (r_state != S_SEARCH);
    w_err       = w_err_sat | w_err_line | w_err_frame;

    // An error always wins over a coincident frame start.
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    if (w_err) begin
      w_state_nxt = S_SEARCH;
    end else if (w_fs) begin
      case (r_state)
        S_SEARCH: begin
          w_state_nxt = S_TRACK;
          w_good_nxt  = '0;
        end
        S_TRACK: begin
          w_good_nxt = r_good + 4'd1;
          if (w_good_nxt == L_LOCK)
            w_state_nxt = S_LOCKED;
        end
        S_LOCKED: ;
        default: w_state_nxt = S_SEARCH;
      endcase
    end

    w_active = (w_hcnt >= L_HA0) && (w_hcnt <= L_HA1) &&
               (w_vcnt >= L_VA0) && (w_vcnt <= L_VA1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_d       <= 1'b1;
      r_v_d       <= 1'b1;
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_pend      <= 1'b0;
      r_state     <= S_SEARCH;
      r_good      <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      r_h_d       <= h_sync;
      r_v_d       <= v_sync;
      r_hcnt      <= w_hcnt;
      r_vcnt      <= w_vcnt;
      r_pend      <= ~w_fs & (r_pend | w_v_fall);
      r_state     <= w_state_nxt;
      r_good      <= w_good_nxt;
      pix_valid   <= w_active & (w_state_nxt == S_LOCKED);
      pix_x       <= w_hcnt[9:0] - L_HA0[9:0];
      pix_y       <= w_vcnt - L_VA0;
      pix_rgb     <= {r_in, g_in, b_in};
      line_start  <= w_h_fall;
      frame_start <= w_fs;
      locked      <= (w_state_nxt == S_LOCKED);
      sync_err    <= w_err;
      if (w_h_fall)
        line_len <= w_line_len;
      if (w_fs)
        frame_lines <= w_frame_lines;
    end
  end

`ifdef VGA_DEC_CHECKSUM_EN
  logic [15:0] r_acc;

  // Accumulates the registered pixel stream; the frame-start cycle never carries a valid pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc     <= '0;
      frame_sum <= '0;
    end else if (w_fs) begin
      frame_sum <= r_acc;
      r_acc     <= '0;
    end else if (pix_valid) begin
      r_acc <= r_acc + {4'b0000, pix_rgb};
    end
  end
`else
  assign frame_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster (17 clocks x 10 lines).
module tb_vga_sync_decoder;

  localparam int HPW = 4;
  localparam int HB  = 3;
  localparam int HD  = 8;
  localparam int HF  = 2;
  localparam int VPW = 2;
  localparam int VB  = 2;
  localparam int VD  = 4;
  localparam int VF  = 2;
  localparam int HT  = HPW + HB + HD + HF;
  localparam int VT  = VPW + VB + VD + VF;

  logic        clk = 1'b0;
  logic        reset;
  logic        h_sync;
  logic        v_sync;
  logic [3:0]  r_in;
  logic [3:0]  g_in;
  logic [3:0]  b_in;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [11:0] pix_rgb;
  logic        line_start;
  logic        frame_start;
  logic        locked;
  logic        sync_err;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic [15:0] frame_sum;

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt  = 0;
  int e0       = 0;
  logic [15:0] exp_sum;

  vga_sync_decoder #(
    .HPW(HPW), .HB(HB), .HD(HD), .HF(HF),
    .VPW(VPW), .VB(VB), .VD(VD), .VF(VF),
    .LOCK_FRAMES(2)
  ) u_dut (
    .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .sync_err(sync_err), .line_len(line_len), .frame_lines(frame_lines),
    .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (sync_err === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ideal generator: one sample per clock; outputs are inspected 1 time unit after the edge.
  task automatic gen_pixel(input int hc, input int vl, input logic [11:0] col);
    h_sync = (hc >= HPW);
    v_sync = (vl >= VPW);
    if (hc >= HPW + HB && hc < HPW + HB + HD && vl >= VPW + VB && vl < VPW + VB + VD)
      {r_in, g_in, b_in} = col;
    else
      {r_in, g_in, b_in} = 12'h000;
    @(posedge clk);
    #1;
  endtask

  task automatic gen_line(input int vl, input int from, input int len, input logic [11:0] col);
    for (int hc = from; hc < len; hc++) gen_pixel(hc, vl, col);
  endtask

  task automatic gen_lines(input int first, input int last, input logic [11:0] col);
    for (int vl = first; vl <= last; vl++) gen_line(vl, 0, HT, col);
  endtask

  task automatic gen_frame(input logic [11:0] col);
    gen_lines(0, VT - 1, col);
  endtask

  initial begin
    reset  = 1'b1;
    h_sync = 1'b1;
    v_sync = 1'b1;
    {r_in, g_in, b_in} = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(sync_err), 32'd0);
    check("rst_line_len", 32'(line_len), 32'd0);
    check("rst_frame_lines", 32'(frame_lines), 32'd0);
    check("rst_sum", 32'(frame_sum), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);

    // Clean stream: lock on the 3rd frame start.
    reset = 1'b0;
    e0 = err_cnt;
    gen_pixel(0, 0, 12'hF00);
    check("fs1_frame_start", 32'(frame_start), 32'd1);
    check("fs1_line_start", 32'(line_start), 32'd1);
    check("fs1_line_len", 32'(line_len), 32'd1);
    check("fs1_frame_lines", 32'(frame_lines), 32'd1);
    check("fs1_locked", 32'(locked), 32'd0);
    gen_line(0, 1, HT, 12'hF00);
    gen_lines(1, VT - 1, 12'hF00);
    gen_frame(12'hF00);
    check("prelock_locked", 32'(locked), 32'd0);
    gen_pixel(0, 0, 12'hF00);
    check("lock_fs3", 32'(locked), 32'd1);
    check("lock_line_len", 32'(line_len), 32'd17);
    check("lock_frame_lines", 32'(frame_lines), 32'd10);

    gen_line(0, 1, HT, 12'hF00);
    gen_lines(1, 3, 12'hF00);
    gen_line(4, 0, 7, 12'hF00);
    gen_pixel(7, 4, 12'hF00);
    check("px0_valid", 32'(pix_valid), 32'd1);
    check("px0_x", 32'(pix_x), 32'd0);
    check("px0_y", 32'(pix_y), 32'd0);
    check("px0_rgb", 32'(pix_rgb), 32'hF00);
    gen_line(4, 8, 15, 12'hF00);
    gen_pixel(15, 4, 12'hF00);
    check("px_hf_valid", 32'(pix_valid), 32'd0);
    gen_line(4, 16, HT, 12'hF00);
    gen_lines(5, 6, 12'hF00);
    gen_line(7, 0, 14, 12'hF00);
    gen_pixel(14, 7, 12'hF00);
    check("pxlast_valid", 32'(pix_valid), 32'd1);
    check("pxlast_x", 32'(pix_x), 32'd7);
    check("pxlast_y", 32'(pix_y), 32'd3);
    gen_line(7, 15, HT, 12'hF00);
    gen_lines(8, VT - 1, 12'hF00);
    check("ideal_no_err", 32'(err_cnt - e0), 32'd0);

    // One short line while locked.
    e0 = err_cnt;
    gen_lines(0, 2, 12'hF00);
    gen_line(3, 0, HT - 1, 12'hF00);
    gen_pixel(0, 4, 12'hF00);
    check("short_err", 32'(sync_err), 32'd1);
    check("short_len", 32'(line_len), 32'd16);
    gen_pixel(1, 4, 12'hF00);
    check("short_unlock", 32'(locked), 32'd0);
    check("short_err_once", 32'(sync_err), 32'd0);
    gen_line(4, 2, HT, 12'hF00);
    gen_lines(5, VT - 1, 12'hF00);
    gen_frame(12'hF00);
    gen_frame(12'hF00);
    check("relock_pre", 32'(locked), 32'd0);
    gen_pixel(0, 0, 12'hF00);
    check("relock", 32'(locked), 32'd1);
    check("short_err_cnt", 32'(err_cnt - e0), 32'd1);

    // h_sync stuck high: hcnt is 16 at the end of line 1 and saturates 2031 clocks later.
    gen_line(0, 1, HT, 12'hF00);
    gen_line(1, 0, HT, 12'hF00);
    e0 = err_cnt;
    h_sync = 1'b1;
    v_sync = 1'b1;
    {r_in, g_in, b_in} = 12'h000;
    repeat (2030) begin
      @(posedge clk);
      #1;
    end
    check("sat_quiet", 32'(err_cnt - e0), 32'd0);
    @(posedge clk);
    #1;
    check("sat_pulse", 32'(sync_err), 32'd1);
    check("sat_unlock", 32'(locked), 32'd0);
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    check("sat_once", 32'(err_cnt - e0), 32'd1);
    check("sat_vfrozen", 32'(pix_y), 32'd1021);
    gen_frame(12'hF00);
    gen_frame(12'hF00);
    gen_pixel(0, 0, 12'hFFF);
    check("sat_relock", 32'(locked), 32'd1);
    check("sat_recover_err", 32'(err_cnt - e0), 32'd1);

    // Checksum over one locked frame of 32 pixels of 12'hFFF: 0x1FFE0 mod 2^16.
    gen_line(0, 1, HT, 12'hFFF);
    gen_lines(1, 3, 12'hFFF);
    gen_line(4, 0, 7, 12'hFFF);
    gen_pixel(7, 4, 12'hFFF);
    check("fff_rgb", 32'(pix_rgb), 32'hFFF);
    gen_line(4, 8, HT, 12'hFFF);
    gen_lines(5, VT - 1, 12'hFFF);
    gen_pixel(0, 0, 12'hF00);
`ifdef VGA_DEC_CHECKSUM_EN
    exp_sum = 16'hFFE0;
`else
    exp_sum = 16'h0000;
`endif
    check("frame_sum", 32'(frame_sum), 32'(exp_sum));

    // Reset in the middle of an active line.
    gen_line(0, 1, HT, 12'hF00);
    gen_lines(1, 3, 12'hF00);
    gen_line(4, 0, 10, 12'hF00);
    reset = 1'b1;
    gen_pixel(10, 4, 12'hF00);
    check("rst2_valid", 32'(pix_valid), 32'd0);
    check("rst2_locked", 32'(locked), 32'd0);
    check("rst2_line_len", 32'(line_len), 32'd0);
    check("rst2_frame_lines", 32'(frame_lines), 32'd0);
    check("rst2_pix_x", 32'(pix_x), 32'd0);
    reset = 1'b0;
    e0 = err_cnt;
    gen_line(4, 11, HT, 12'hF00);
    gen_lines(5, VT - 1, 12'hF00);
    gen_frame(12'hF00);
    gen_frame(12'hF00);
    check("rst2_prelock", 32'(locked), 32'd0);
    gen_pixel(0, 0, 12'hF00);
    check("rst2_lock", 32'(locked), 32'd1);
    check("rst2_no_err", 32'(err_cnt - e0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
